// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, legal
// byte-lane masks, access sizes and default geometry/latency.
package dmem_pkg;

  localparam int DMEM_DEPTH_DEFAULT   = 1024;
  localparam int DMEM_LATENCY_DEFAULT = 2;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Access width implied by the lane mask.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dmem_size_t;

  // The only masks the responder acts on; anything else is a no-op.
  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // True for the half-word masks (used for the alignment check).
  function automatic logic mask_is_half(input logic [3:0] m);
    return (m == MASK_H0) || (m == MASK_H1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator and the data-memory responder.
// Signal names keep the responder's point of view (i_ = into the responder).
// o_rsp_err only exists when DMEM_ERR_EN is defined.
interface dmem_responder_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [31:0] i_addr;
  logic [3:0]  i_mask;
  logic        i_unsigned;
  logic [31:0] i_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rdata;
`ifdef DMEM_ERR_EN
  logic        o_rsp_err;
`endif

  // Initiator side: drives requests, takes responses.
  modport master (
    output i_req_valid,
    input  o_req_ready,
    output i_req_write,
    output i_addr,
    output i_mask,
    output i_unsigned,
    output i_wdata,
    input  o_rsp_valid,
    output i_rsp_ready,
`ifdef DMEM_ERR_EN
    input  o_rsp_err,
`endif
    input  o_rdata
  );

  // Responder side.
  modport slave (
    input  i_req_valid,
    output o_req_ready,
    input  i_req_write,
    input  i_addr,
    input  i_mask,
    input  i_unsigned,
    input  i_wdata,
    output o_rsp_valid,
    input  i_rsp_ready,
`ifdef DMEM_ERR_EN
    output o_rsp_err,
`endif
    output o_rdata
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the responder: shifts store data into the
// enabled byte lanes and pulls load data down to bit 0 with sign/zero
// extension. Illegal masks produce no byte enables and zero load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [3:0]  mask,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        legal,
  output logic [3:0]  wbe,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [1:0]  lane;
  dmem_size_t  size;
  logic [31:0] shifted;
  logic        sign_bit;

  // Decode the mask into a lowest-lane offset and an access size.
  always_comb begin
    legal = 1'b1;
    lane  = 2'd0;
    size  = SZ_WORD;
    case (mask)
      MASK_B0: begin lane = 2'd0; size = SZ_BYTE; end
      MASK_B1: begin lane = 2'd1; size = SZ_BYTE; end
      MASK_B2: begin lane = 2'd2; size = SZ_BYTE; end
      MASK_B3: begin lane = 2'd3; size = SZ_BYTE; end
      MASK_H0: begin lane = 2'd0; size = SZ_HALF; end
      MASK_H1: begin lane = 2'd2; size = SZ_HALF; end
      MASK_W:  begin lane = 2'd0; size = SZ_WORD; end
      default: legal = 1'b0;
    endcase
  end

  // One byte enable per lane, only for a recognised mask.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wbe
      assign wbe[gi] = legal & mask[gi];
    end
  endgenerate

  assign wword   = legal ? (wdata << {lane, 3'b000}) : 32'd0;
  assign shifted = rword >> {lane, 3'b000};

  // Extend from the top enabled bit; zero-extend when is_unsigned is set.
  always_comb begin
    rdata    = 32'd0;
    sign_bit = 1'b0;
    if (legal) begin
      case (size)
        SZ_BYTE: begin
          sign_bit = ~is_unsigned & shifted[7];
          rdata    = {{24{sign_bit}}, shifted[7:0]};
        end
        SZ_HALF: begin
          sign_bit = ~is_unsigned & shifted[15];
          rdata    = {{16{sign_bit}}, shifted[15:0]};
        end
        default: rdata = shifted;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a fixed request-to-response latency.
// One access in flight at a time: IDLE accepts, WAIT burns LATENCY-1 cycles,
// RESP holds the result until the initiator takes it.
// Optional feature macro: DMEM_ERR_EN adds o_rsp_err and flags illegal masks,
// misaligned halves and out-of-range addresses (otherwise addresses alias).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEFAULT,   // 32-bit words, power of two
  parameter int LATENCY = DMEM_LATENCY_DEFAULT  // 1..15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] WAIT_LAST = CW'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  dmem_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Request fields held for the duration of the access.
  logic          cap_write_reg;
  logic [AW-1:0] cap_idx_reg;
  logic [3:0]    cap_mask_reg;
  logic          cap_uns_reg;
  logic [31:0]   cap_wdata_reg;
  logic          cap_ok_reg;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word_reg;

  logic          is_idle;
  logic          accept;
  logic          enter_resp;
  logic          addr_ok_in;
  logic          req_ok;
  logic          addr_unused;

  // Operation fields: straight from the bus while idle (so LATENCY=1 can
  // commit on the acceptance edge), from the capture registers afterwards.
  logic          op_write;
  logic [AW-1:0] op_idx;
  logic [3:0]    op_mask;
  logic          op_uns;
  logic [31:0]   op_wdata;
  logic          op_ok;

  logic          al_legal;
  logic [3:0]    al_wbe;
  logic [31:0]   al_wword;
  logic [31:0]   al_rdata;

  logic          mem_we;
  logic          mem_re;

  assign is_idle  = (state_reg == ST_IDLE);
  assign accept   = bus.i_req_valid & bus.o_req_ready;

  assign op_write = is_idle ? bus.i_req_write      : cap_write_reg;
  assign op_idx   = is_idle ? bus.i_addr[AW+1:2]   : cap_idx_reg;
  assign op_mask  = is_idle ? bus.i_mask           : cap_mask_reg;
  assign op_uns   = is_idle ? bus.i_unsigned       : cap_uns_reg;
  assign op_wdata = is_idle ? bus.i_wdata          : cap_wdata_reg;

`ifdef DMEM_ERR_EN
  logic addr_in_range;
  logic half_misaligned;
  assign addr_in_range   = (bus.i_addr >> (AW + 2)) == 32'd0;
  assign half_misaligned = bus.i_addr[0] & mask_is_half(bus.i_mask);
  assign addr_ok_in      = addr_in_range & ~half_misaligned;
  assign addr_unused     = bus.i_addr[1];
`else
  // Upper address bits are ignored, so the array aliases across the space.
  assign addr_ok_in      = 1'b1;
  assign addr_unused     = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0]};
`endif

  // While idle the aligner sees the bus mask, so al_legal judges the request.
  assign req_ok = al_legal & addr_ok_in;
  assign op_ok  = is_idle ? req_ok : cap_ok_reg;

  dmem_lane_align u_align (
    .mask        (op_mask),
    .is_unsigned (op_uns),
    .wdata       (op_wdata),
    .rword       (rd_word_reg),
    .legal       (al_legal),
    .wbe         (al_wbe),
    .wword       (al_wword),
    .rdata       (al_rdata)
  );

  // The array is touched only on the edge that enters RESP.
  assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);
  assign mem_we     = enter_resp & op_write & op_ok;
  assign mem_re     = enter_resp & ~op_write;

  // State register and latency counter; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: IDLE -> WAIT (or RESP for LATENCY=1) -> RESP -> IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Capture the request on acceptance; these also drive the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_write_reg <= 1'b0;
      cap_idx_reg   <= '0;
      cap_mask_reg  <= '0;
      cap_uns_reg   <= 1'b0;
      cap_wdata_reg <= '0;
      cap_ok_reg    <= 1'b0;
    end else if (accept) begin
      cap_write_reg <= bus.i_req_write;
      cap_idx_reg   <= bus.i_addr[AW+1:2];
      cap_mask_reg  <= bus.i_mask;
      cap_uns_reg   <= bus.i_unsigned;
      cap_wdata_reg <= bus.i_wdata;
      cap_ok_reg    <= req_ok;
    end
  end

  // Storage: byte-enabled write and registered read, no reset so it maps to
  // block RAM and survives reset untouched.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (al_wbe[i]) begin
          mem[op_idx][8*i +: 8] <= al_wword[8*i +: 8];
        end
      end
    end
    if (mem_re) begin
      rd_word_reg <= mem[op_idx];
    end
  end

  // Outputs are decoded from registers only, so they hold steady in RESP and
  // read as zero the instant reset asserts.
  assign bus.o_req_ready = is_idle & i_rst_n;
  assign bus.o_rsp_valid = (state_reg == ST_RESP);
  assign bus.o_rdata     = ((state_reg == ST_RESP) && !cap_write_reg && cap_ok_reg)
                           ? al_rdata : 32'd0;
`ifdef DMEM_ERR_EN
  assign bus.o_rsp_err   = (state_reg == ST_RESP) & ~cap_ok_reg;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an expected-response scoreboard.
// Honors DMEM_ERR_EN the same way as the design.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = DMEM_DEPTH_DEFAULT;
  localparam int LAT   = DMEM_LATENCY_DEFAULT;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus_if ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [3:0] m,
                           input logic u, input logic [31:0] wd);
    bus_if.i_req_write = wr;
    bus_if.i_addr      = a;
    bus_if.i_mask      = m;
    bus_if.i_unsigned  = u;
    bus_if.i_wdata     = wd;
    bus_if.i_req_valid = 1'b1;
  endtask

  // Wait (bounded) until the responder is ready; we are #1 after an edge.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus_if.o_req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("%s accept", tag), {31'd0, bus_if.o_req_ready}, 32'd1);
  endtask

  // One full transaction: issue, check latency, optional back-pressure, check data.
  task automatic xact(input string tag, input logic wr, input logic [31:0] a,
                      input logic [3:0] m, input logic u, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input int hold);
    exp_t        e;
    int          lat;
    logic [31:0] held;
    sb.push_back('{rdata: exp_d, err: exp_e});
    drive_req(wr, a, m, u, wd);
    wait_ready(tag);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      bus_if.i_req_valid = 1'b0;
    end while (bus_if.o_rsp_valid !== 1'b1 && lat < 40);
    chk($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
    held = bus_if.o_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("%s hold valid", tag), {31'd0, bus_if.o_rsp_valid}, 32'd1);
      chk($sformatf("%s hold rdata", tag), bus_if.o_rdata, held);
      chk($sformatf("%s hold ready", tag), {31'd0, bus_if.o_req_ready}, 32'd0);
    end
    e = sb.pop_front();
    chk($sformatf("%s rdata", tag), bus_if.o_rdata, e.rdata);
`ifdef DMEM_ERR_EN
    chk($sformatf("%s err", tag), {31'd0, bus_if.o_rsp_err}, {31'd0, e.err});
`endif
    $display("xact %s wr=%0d addr=%h mask=%b uns=%0d wdata=%h rdata=%h lat=%0d",
             tag, wr, a, m, u, wd, bus_if.o_rdata, lat);
    bus_if.i_rsp_ready = 1'b1;
    chk($sformatf("%s ready in resp", tag), {31'd0, bus_if.o_req_ready}, 32'd0);
    @(posedge clk); #1;
    bus_if.i_rsp_ready = 1'b0;
    chk($sformatf("%s valid drop", tag), {31'd0, bus_if.o_rsp_valid}, 32'd0);
    chk($sformatf("%s ready after", tag), {31'd0, bus_if.o_req_ready}, 32'd1);
  endtask

  initial begin
    bus_if.i_req_valid = 1'b0;
    bus_if.i_req_write = 1'b0;
    bus_if.i_addr      = 32'd0;
    bus_if.i_mask      = 4'd0;
    bus_if.i_unsigned  = 1'b0;
    bus_if.i_wdata     = 32'd0;
    bus_if.i_rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, bus_if.o_req_ready}, 32'd0);
    chk("reset valid", {31'd0, bus_if.o_rsp_valid}, 32'd0);
    chk("reset rdata", bus_if.o_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-reset ready", {31'd0, bus_if.o_req_ready}, 32'd1);
    @(posedge clk); #1;

    // Word store/load.
    xact("st_w10",  1'b1, 32'h10, MASK_W,  1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("ld_w10",  1'b0, 32'h10, MASK_W,  1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte store into lane 2 and extraction variants.
    xact("st_b2",   1'b1, 32'h10, MASK_B2, 1'b0, 32'h00000080, 32'h0, 1'b0, 0);
    xact("ld_b2s",  1'b0, 32'h10, MASK_B2, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact("ld_b2u",  1'b0, 32'h10, MASK_B2, 1'b1, 32'h0, 32'h00000080, 1'b0, 0);
    xact("ld_w10b", 1'b0, 32'h10, MASK_W,  1'b0, 32'h0, 32'hDE80BEEF, 1'b0, 0);
    xact("ld_h1s",  1'b0, 32'h10, MASK_H1, 1'b0, 32'h0, 32'hFFFFDE80, 1'b0, 0);
    xact("ld_h0u",  1'b0, 32'h10, MASK_H0, 1'b1, 32'h0, 32'h0000BEEF, 1'b0, 0);
    xact("ld_b0s",  1'b0, 32'h10, MASK_B0, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
    xact("ld_b3u",  1'b0, 32'h10, MASK_B3, 1'b1, 32'h0, 32'h000000DE, 1'b0, 0);

    // Half store into the upper lanes.
    xact("st_w30",  1'b1, 32'h30, MASK_W,  1'b0, 32'h00000000, 32'h0, 1'b0, 0);
    xact("st_h30",  1'b1, 32'h30, MASK_H1, 1'b0, 32'h0000ABCD, 32'h0, 1'b0, 0);
    xact("ld_w30",  1'b0, 32'h30, MASK_W,  1'b0, 32'h0, 32'hABCD0000, 1'b0, 0);
    xact("ld_h30s", 1'b0, 32'h30, MASK_H1, 1'b0, 32'h0, 32'hFFFFABCD, 1'b0, 0);

    // Back-pressure: response held for 5 cycles.
    xact("ld_hold", 1'b0, 32'h10, MASK_W,  1'b0, 32'h0, 32'hDE80BEEF, 1'b0, 5);

    // Reset one cycle after accepting a store: the store must be lost.
    xact("st_w20",  1'b1, 32'h20, MASK_W,  1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    drive_req(1'b1, 32'h20, MASK_W, 1'b0, 32'h12345678);
    wait_ready("st_abort");
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort valid", {31'd0, bus_if.o_rsp_valid}, 32'd0);
    chk("abort rdata", bus_if.o_rdata, 32'd0);
    chk("abort ready", {31'd0, bus_if.o_req_ready}, 32'd0);
    $display("xact st_abort wr=1 addr=00000020 reset mid-operation");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact("ld_w20",  1'b0, 32'h20, MASK_W,  1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Illegal masks are no-ops.
    xact("st_bad",  1'b1, 32'h10, 4'b0101, 1'b0, 32'hFFFFFFFF, 32'h0, ERR_EN, 0);
    xact("ld_bad0", 1'b0, 32'h10, 4'b0000, 1'b0, 32'h0, 32'h0, ERR_EN, 0);
    xact("ld_w10c", 1'b0, 32'h10, MASK_W,  1'b0, 32'h0, 32'hDE80BEEF, 1'b0, 0);

    // Out-of-range address: error, or aliases onto word 0.
    xact("st_w0",   1'b1, 32'h0,  MASK_W,  1'b0, 32'h11223344, 32'h0, 1'b0, 0);
    xact("ld_oor",  1'b0, 32'(DEPTH*4), MASK_W, 1'b0, 32'h0,
         ERR_EN ? 32'h0 : 32'h11223344, ERR_EN, 0);

`ifdef DMEM_ERR_EN
    // Misaligned half load is an error with zero data.
    xact("ld_mis",  1'b0, 32'h11, MASK_H0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
`endif

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
